// File: rtl/uart_autobaud_ctrl_pkg.sv
// rtl/uart_autobaud_ctrl_pkg.sv - shared types and widths for the UART autobaud controller (package uart_pkg)
package uart_pkg;

    localparam int BAUD_W     = 13;
    localparam int FRAC_W     = 3;
    localparam int CNT_W      = 20;
    localparam int SYNC_EDGES = 5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_START,
        MEASURE,
        COMMIT,
        LOCKED,
        ERR
    } ab_state_t;

    // True when interval i lies within +/-25% of the reference interval ref_i.
    function automatic logic in_window(input logic [CNT_W-1:0] i, input logic [CNT_W-1:0] ref_i);
        logic [CNT_W:0] lo;
        logic [CNT_W:0] hi;
        lo = {1'b0, ref_i} - {3'b000, ref_i[CNT_W-1:2]};
        hi = {1'b0, ref_i} + {3'b000, ref_i[CNT_W-1:2]};
        return ({1'b0, i} >= lo) && ({1'b0, i} <= hi);
    endfunction

endpackage

// File: rtl/uart_rx_edge_sync.sv
// rtl/uart_rx_edge_sync.sv - 2-FF rx synchroniser with a registered-history falling-edge pulse
module uart_rx_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic rx_meta;
    logic rx_prev;

    // Line idles high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// rtl/uart_autobaud_ctrl.sv - baud_val/fraction source for the 16x baud generator; UART_AUTOBAUD_FRCTN_EN enables fraction output
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter logic [BAUD_W-1:0] RESET_BAUD_VAL = 13'd26,
    parameter logic [CNT_W-1:0]  IDLE_CYCLES    = 20'd4096,
    parameter logic [CNT_W-1:0]  MIN_COUNT      = 20'd256,
    parameter logic [CNT_W-1:0]  TIMEOUT        = 20'hFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              autobaud_en,
    input  logic              start,
    input  logic              rx,
    input  logic              tx_busy,
    input  logic              baud_clock,
    input  logic [BAUD_W-1:0] man_baud_val,
    input  logic [FRAC_W-1:0] man_fraction,
    output logic [BAUD_W-1:0] baud_val,
    output logic [FRAC_W-1:0] baud_val_fraction,
    output logic              busy,
    output logic              locked,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       LAST_CNT = 3'(SYNC_EDGES - 1);

    ab_state_t         state;
    logic [CNT_W-1:0]  idle_cnt;
    logic [CNT_W-1:0]  n_cnt;
    logic [CNT_W-1:0]  last_edge;
    logic [CNT_W-1:0]  i1;
    logic [2:0]        edge_cnt;

    logic              rx_sync;
    logic              rx_fall;
    logic [CNT_W-1:0]  n_next;
    logic [CNT_W-1:0]  interval;
    logic [BAUD_W-1:0] n_hi;
    logic [BAUD_W-1:0] nv;
    logic [FRAC_W-1:0] nf;
    logic [FRAC_W-1:0] man_frac_eff;

    uart_rx_edge_sync u_rx_sync (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    // n_next is the count of cycles since the first edge as of this cycle; saturates.
    assign n_next   = (n_cnt == '1) ? n_cnt : n_cnt + CNT_ONE;
    assign interval = n_next - last_edge;
    assign n_hi     = n_cnt[CNT_W-1:7];

`ifdef UART_AUTOBAUD_FRCTN_EN
    assign nv           = n_hi - 13'd1;
    assign nf           = n_cnt[6:4];
    assign man_frac_eff = man_fraction;
`else
    logic unused_man_fraction;
    assign unused_man_fraction = ^man_fraction;
    // Without a fractional divider, round N/128 to nearest instead of truncating.
    assign nv           = n_hi - 13'd1 + {12'd0, n_cnt[6]};
    assign nf           = '0;
    assign man_frac_eff = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            idle_cnt          <= '0;
            n_cnt             <= '0;
            last_edge         <= '0;
            i1                <= '0;
            edge_cnt          <= '0;
            baud_val          <= RESET_BAUD_VAL;
            baud_val_fraction <= '0;
            busy              <= 1'b0;
            locked            <= 1'b0;
            err               <= 1'b0;
        end else if (!autobaud_en) begin
            state             <= IDLE;
            busy              <= 1'b0;
            locked            <= 1'b0;
            baud_val          <= man_baud_val;
            baud_val_fraction <= man_frac_eff;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_IDLE;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                WAIT_IDLE: begin
                    if (!rx_sync) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt + CNT_ONE >= IDLE_CYCLES) begin
                        state <= WAIT_START;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_ONE;
                    end
                end
                WAIT_START: begin
                    if (rx_fall) begin
                        state     <= MEASURE;
                        n_cnt     <= '0;
                        last_edge <= '0;
                        edge_cnt  <= 3'd1;
                    end
                end
                MEASURE: begin
                    n_cnt <= n_next;
                    if (n_next >= TIMEOUT) begin
                        state <= ERR;
                    end else if (rx_fall) begin
                        edge_cnt  <= edge_cnt + 3'd1;
                        last_edge <= n_next;
                        if (edge_cnt == 3'd1) begin
                            i1 <= interval;
                        end else if (!in_window(interval, i1)) begin
                            state <= ERR;
                        end else if (edge_cnt == LAST_CNT) begin
                            state <= (n_next < MIN_COUNT) ? ERR : COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (n_hi == '0) begin
                        state <= ERR;
                    end else if (baud_clock && !tx_busy) begin
                        baud_val          <= nv;
                        baud_val_fraction <= nf;
                        locked            <= 1'b1;
                        busy              <= 1'b0;
                        state             <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (start) begin
                        state    <= WAIT_IDLE;
                        locked   <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                ERR: begin
                    err    <= 1'b1;
                    busy   <= 1'b0;
                    locked <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// tb/tb_uart_autobaud_ctrl.sv - directed table-driven bench for uart_autobaud_ctrl (honours UART_AUTOBAUD_FRCTN_EN)
module tb_uart_autobaud_ctrl;

    localparam logic [19:0] TB_TIMEOUT = 20'd6000;
`ifdef UART_AUTOBAUD_FRCTN_EN
    localparam bit FRC = 1'b1;
`else
    localparam bit FRC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        autobaud_en = 1'b1;
    logic        start = 1'b0;
    logic        rx = 1'b1;
    logic        tx_busy = 1'b0;
    logic        baud_clock = 1'b0;
    logic [12:0] man_baud_val = '0;
    logic [2:0]  man_fraction = '0;
    logic [12:0] baud_val;
    logic [2:0]  baud_val_fraction;
    logic        busy;
    logic        locked;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    uart_autobaud_ctrl #(
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .autobaud_en       (autobaud_en),
        .start             (start),
        .rx                (rx),
        .tx_busy           (tx_busy),
        .baud_clock        (baud_clock),
        .man_baud_val      (man_baud_val),
        .man_fraction      (man_fraction),
        .baud_val          (baud_val),
        .baud_val_fraction (baud_val_fraction),
        .busy              (busy),
        .locked            (locked),
        .err               (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] bv;
        logic [2:0]  fr;
    } man_vec_t;

    typedef struct {
        logic [7:0]  ch;
        int          bit_cyc;
        logic        exp_err;
        logic [12:0] exp_bv;
        logic [2:0]  exp_fr;
    } auto_vec_t;

    man_vec_t  mv[4];
    auto_vec_t av[5];
    logic [12:0] prev_bv;
    logic [2:0]  prev_fr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] ch, input int t);
        rx = 1'b0;
        cyc(t);
        for (int b = 0; b < 8; b++) begin
            rx = ch[b];
            cyc(t);
        end
        rx = 1'b1;
        cyc(t);
    endtask

    task automatic baud_pulse();
        baud_clock = 1'b1;
        cyc(1);
        baud_clock = 1'b0;
    endtask

    function automatic logic [2:0] exp_frac(input logic [2:0] f);
        return FRC ? f : 3'd0;
    endfunction

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mv[0] = '{13'd100, 3'd3};
        mv[1] = '{13'd0, 3'd7};
        mv[2] = '{13'd8191, 3'd0};
        mv[3] = '{13'd1234, 3'd5};

        // N = 8 * bit_cyc: 3472 -> 26/1, 800 -> 5/2, 1600 -> 11/4 (rounded 12/0)
        av[0] = '{8'h33, 434, 1'b1, 13'd0, 3'd0};
        av[1] = '{8'h55, 434, 1'b0, 13'd26, FRC ? 3'd1 : 3'd0};
        av[2] = '{8'h55, 100, 1'b0, 13'd5, FRC ? 3'd2 : 3'd0};
        av[3] = '{8'h55, 20, 1'b1, 13'd0, 3'd0};
        av[4] = '{8'h55, 200, 1'b0, FRC ? 13'd11 : 13'd12, FRC ? 3'd4 : 3'd0};

        cyc(3);
        reset = 1'b0;
        cyc(2);
        check("rst_bv", baud_val, 13'd26);
        check("rst_fr", baud_val_fraction, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_err", err, 1'b0);

        autobaud_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            man_baud_val = mv[k].bv;
            man_fraction = mv[k].fr;
            cyc(1);
            check($sformatf("man%0d_bv", k), baud_val, mv[k].bv);
            check($sformatf("man%0d_fr", k), baud_val_fraction, exp_frac(mv[k].fr));
            check($sformatf("man%0d_locked", k), locked, 1'b0);
        end
        prev_bv = 13'd1234;
        prev_fr = exp_frac(3'd5);

        autobaud_en = 1'b1;
        cyc(1);
        for (int k = 0; k < 5; k++) begin
            pulse_start();
            cyc(5000);
            send_char(av[k].ch, av[k].bit_cyc);
            cyc(20);
            if (av[k].exp_err) begin
                check($sformatf("v%0d_err", k), err, 1'b1);
                check($sformatf("v%0d_locked", k), locked, 1'b0);
                check($sformatf("v%0d_busy", k), busy, 1'b0);
                check($sformatf("v%0d_bv_kept", k), baud_val, prev_bv);
                check($sformatf("v%0d_fr_kept", k), baud_val_fraction, prev_fr);
            end else begin
                check($sformatf("v%0d_wait_busy", k), busy, 1'b1);
                check($sformatf("v%0d_wait_bv", k), baud_val, prev_bv);
                tx_busy = 1'b1;
                repeat (3) begin
                    baud_pulse();
                    cyc(15);
                end
                check($sformatf("v%0d_txb_busy", k), busy, 1'b1);
                check($sformatf("v%0d_txb_bv", k), baud_val, prev_bv);
                check($sformatf("v%0d_txb_locked", k), locked, 1'b0);
                tx_busy = 1'b0;
                cyc(5);
                check($sformatf("v%0d_nobclk_busy", k), busy, 1'b1);
                baud_pulse();
                check($sformatf("v%0d_bv", k), baud_val, av[k].exp_bv);
                check($sformatf("v%0d_fr", k), baud_val_fraction, av[k].exp_fr);
                check($sformatf("v%0d_locked", k), locked, 1'b1);
                check($sformatf("v%0d_busy", k), busy, 1'b0);
                check($sformatf("v%0d_err", k), err, 1'b0);
                prev_bv = av[k].exp_bv;
                prev_fr = av[k].exp_fr;
            end
        end

        // rx stuck low after the first edge: MEASURE must time out
        pulse_start();
        cyc(5000);
        rx = 1'b0;
        begin
            int w;
            w = 0;
            while (!err && w < 7000) begin
                cyc(1);
                w++;
            end
            check("timeout_err", err, 1'b1);
            check("timeout_not_early", (w >= 5990), 1'b1);
        end
        rx = 1'b1;
        check("timeout_bv_kept", baud_val, prev_bv);
        check("timeout_locked", locked, 1'b0);

        // abort mid-MEASURE by dropping autobaud_en
        pulse_start();
        cyc(5000);
        rx = 1'b0;
        cyc(434 * 3);
        man_baud_val = 13'd77;
        man_fraction = 3'd5;
        autobaud_en = 1'b0;
        cyc(2);
        rx = 1'b1;
        check("abort_bv", baud_val, 13'd77);
        check("abort_fr", baud_val_fraction, exp_frac(3'd5));
        check("abort_busy", busy, 1'b0);
        check("abort_locked", locked, 1'b0);

        // reset while parked in COMMIT
        autobaud_en = 1'b1;
        cyc(1);
        pulse_start();
        cyc(5000);
        tx_busy = 1'b1;
        send_char(8'h55, 100);
        cyc(10);
        check("commit_busy", busy, 1'b1);
        check("commit_bv_held", baud_val, 13'd77);
        reset = 1'b1;
        #1;
        check("rst_mid_bv", baud_val, 13'd26);
        check("rst_mid_fr", baud_val_fraction, 3'd0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_locked", locked, 1'b0);
        check("rst_mid_err", err, 1'b0);
        cyc(2);
        reset = 1'b0;
        tx_busy = 1'b0;
        baud_pulse();
        cyc(2);
        check("post_rst_bv", baud_val, 13'd26);
        check("post_rst_locked", locked, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
